// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect #(
    parameter int ADDR_LEFT = 4
) (
    input  logic [ADDR_LEFT:0] i_rs_s2,
    input  logic [ADDR_LEFT:0] i_rt_s2,
    input  logic               i_uses_rs_s2,
    input  logic               i_uses_rt_s2,
    input  logic               i_sel_mem_s3,
    input  logic               i_rw_s3,
    input  logic [ADDR_LEFT:0] i_waddr_s3,
    output logic               o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_dst;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_load_dst = i_sel_mem_s3 & i_rw_s3 & (i_waddr_s3 != {(ADDR_LEFT+1){1'b0}});
    assign w_rs_hit   = i_uses_rs_s2 & (i_rs_s2 == i_waddr_s3);
    assign w_rt_hit   = i_uses_rt_s2 & (i_rt_s2 == i_waddr_s3);
    assign o_load_use = w_load_dst & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, halt drain, branch flush and load-use stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
    parameter int CNT_BITS  = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [ADDR_LEFT:0]  rs_s2,
    input  logic [ADDR_LEFT:0]  rt_s2,
    input  logic                uses_rs_s2,
    input  logic                uses_rt_s2,
    input  logic                sel_mem_s3,
    input  logic                rw_s3,
    input  logic [ADDR_LEFT:0]  waddr_s3,
    input  logic                branch_taken_s3,
    input  logic                mem_req_s4,
    input  logic                mem_ack,
    input  logic                halt_s4,
    output logic                stall_pc,
    output logic                hold_if_id,
    output logic                hold_id_ex,
    output logic                hold_ex_mem,
    output logic                bubble_id_ex,
    output logic                bubble_mem_wb,
    output logic                flush_if_id,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_drain_cnt;
    logic [1:0]          w_drain_next;
    logic [CNT_BITS-1:0] r_stall_cnt;
    logic                w_load_use;
    logic                w_mem_stall;

    load_use_detect #(.ADDR_LEFT(ADDR_LEFT)) u_load_use_detect (
        .i_rs_s2      (rs_s2),
        .i_rt_s2      (rt_s2),
        .i_uses_rs_s2 (uses_rs_s2),
        .i_uses_rt_s2 (uses_rt_s2),
        .i_sel_mem_s3 (sel_mem_s3),
        .i_rw_s3      (rw_s3),
        .i_waddr_s3   (waddr_s3),
        .o_load_use   (w_load_use)
    );

    assign w_mem_stall = mem_req_s4 & ~mem_ack;
    assign stall_cnt   = r_stall_cnt;

    // Next-state and control decode from current state and stage inputs.
    always_comb begin
        w_next_state  = r_state;
        w_drain_next  = r_drain_cnt;
        stall_pc      = 1'b0;
        hold_if_id    = 1'b0;
        hold_id_ex    = 1'b0;
        hold_ex_mem   = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_mem_wb = 1'b0;
        flush_if_id   = 1'b0;
        halted        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    stall_pc      = 1'b1;
                    hold_if_id    = 1'b1;
                    hold_id_ex    = 1'b1;
                    hold_ex_mem   = 1'b1;
                    bubble_mem_wb = 1'b1;
                    w_next_state  = ST_MEM_WAIT;
                end else if (halt_s4) begin
                    stall_pc     = 1'b1;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    w_drain_next = DRAIN_CYCLES;
                    w_next_state = ST_DRAIN;
                end else if (branch_taken_s3) begin
                    // The squashed ID instruction cannot cause a load-use stall.
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (w_load_use) begin
                    stall_pc     = 1'b1;
                    hold_if_id   = 1'b1;
                    bubble_id_ex = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ack) begin
                    stall_pc      = 1'b1;
                    hold_if_id    = 1'b1;
                    hold_id_ex    = 1'b1;
                    hold_ex_mem   = 1'b1;
                    bubble_mem_wb = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A memory stall freezes the drain; the ID/EX bubble would conflict with its hold.
                if (w_mem_stall) begin
                    stall_pc      = 1'b1;
                    hold_if_id    = 1'b1;
                    hold_id_ex    = 1'b1;
                    hold_ex_mem   = 1'b1;
                    bubble_mem_wb = 1'b1;
                end else begin
                    stall_pc     = 1'b1;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    if (r_drain_cnt <= 2'd1) begin
                        w_drain_next = 2'd0;
                        w_next_state = ST_HALTED;
                    end else begin
                        w_drain_next = r_drain_cnt - 2'd1;
                    end
                end
            end
            ST_HALTED: begin
                halted       = 1'b1;
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
            default: begin
                w_next_state = ST_RUN;
                w_drain_next = 2'd0;
            end
        endcase
    end

    // State and drain counter registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_next;
        end
    end

    // Saturating count of PC-stall cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_stall_cnt <= {CNT_BITS{1'b0}};
        end else if (stall_pc && (r_stall_cnt != {CNT_BITS{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int AL = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic [AL:0] rs_s2, rt_s2, waddr_s3;
    logic uses_rs_s2, uses_rt_s2, sel_mem_s3, rw_s3, branch_taken_s3;
    logic mem_req_s4, mem_ack, halt_s4;

    logic stall_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic bubble_id_ex, bubble_mem_wb, flush_if_id, halted;
    logic [15:0] stall_cnt;

    logic s_stall_pc, s_hold_if_id, s_hold_id_ex, s_hold_ex_mem;
    logic s_bubble_id_ex, s_bubble_mem_wb, s_flush_if_id, s_halted;
    logic [3:0] s_stall_cnt;

    int checks = 0;
    int failures = 0;

    // Output vector: {halted, stall_pc, hold_if_id, hold_id_ex, hold_ex_mem, bubble_id_ex, bubble_mem_wb, flush_if_id}
    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_MEM   = 8'h7A;
    localparam logic [7:0] O_DRAIN = 8'h45;
    localparam logic [7:0] O_HALT  = 8'hC5;
    localparam logic [7:0] O_BR    = 8'h05;
    localparam logic [7:0] O_LU    = 8'h64;

    wire [7:0] got = {halted, stall_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                      bubble_id_ex, bubble_mem_wb, flush_if_id};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_(rst_), .rs_s2(rs_s2), .rt_s2(rt_s2),
        .uses_rs_s2(uses_rs_s2), .uses_rt_s2(uses_rt_s2),
        .sel_mem_s3(sel_mem_s3), .rw_s3(rw_s3), .waddr_s3(waddr_s3),
        .branch_taken_s3(branch_taken_s3), .mem_req_s4(mem_req_s4),
        .mem_ack(mem_ack), .halt_s4(halt_s4),
        .stall_pc(stall_pc), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
        .hold_ex_mem(hold_ex_mem), .bubble_id_ex(bubble_id_ex),
        .bubble_mem_wb(bubble_mem_wb), .flush_if_id(flush_if_id),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_BITS(4)) dut_s (
        .clk(clk), .rst_(rst_), .rs_s2(rs_s2), .rt_s2(rt_s2),
        .uses_rs_s2(uses_rs_s2), .uses_rt_s2(uses_rt_s2),
        .sel_mem_s3(sel_mem_s3), .rw_s3(rw_s3), .waddr_s3(waddr_s3),
        .branch_taken_s3(branch_taken_s3), .mem_req_s4(mem_req_s4),
        .mem_ack(mem_ack), .halt_s4(halt_s4),
        .stall_pc(s_stall_pc), .hold_if_id(s_hold_if_id), .hold_id_ex(s_hold_id_ex),
        .hold_ex_mem(s_hold_ex_mem), .bubble_id_ex(s_bubble_id_ex),
        .bubble_mem_wb(s_bubble_mem_wb), .flush_if_id(s_flush_if_id),
        .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: outstanding memory wait, drain cycles left, halted flag, stall counts.
    bit m_wait = 1'b0;
    int m_drain = 0;
    bit m_halted = 1'b0;
    int m_cnt = 0;
    int m_cnt_s = 0;

    always @(negedge clk) begin
        bit lu, ms;
        logic [7:0] e;
        if (!rst_) begin
            m_wait = 1'b0; m_drain = 0; m_halted = 1'b0; m_cnt = 0; m_cnt_s = 0;
        end
        lu = sel_mem_s3 && rw_s3 && (waddr_s3 != 0) &&
             ((uses_rs_s2 && rs_s2 == waddr_s3) || (uses_rt_s2 && rt_s2 == waddr_s3));
        ms = mem_req_s4 && !mem_ack;
        e = O_NONE;
        if (m_halted) e = O_HALT;
        else if (m_wait) begin
            if (!mem_ack) e = O_MEM;
            else m_wait = 1'b0;
        end else if (m_drain > 0) begin
            if (ms) e = O_MEM;
            else begin
                e = O_DRAIN;
                m_drain--;
                if (m_drain == 0) m_halted = 1'b1;
            end
        end else if (ms) begin
            e = O_MEM; m_wait = 1'b1;
        end else if (halt_s4) begin
            e = O_DRAIN; m_drain = 2;
        end else if (branch_taken_s3) e = O_BR;
        else if (lu) e = O_LU;

        check("outputs", {24'd0, got}, {24'd0, e});
        check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        check("stall_cnt_sat4", {28'd0, s_stall_cnt}, m_cnt_s);
        check("id_ex_hold_and_bubble", {31'd0, hold_id_ex & bubble_id_ex}, 32'd0);
        check("if_id_hold_and_flush", {31'd0, hold_if_id & flush_if_id}, 32'd0);

        if (!rst_) begin
            m_wait = 1'b0; m_drain = 0; m_halted = 1'b0; m_cnt = 0; m_cnt_s = 0;
        end else if (e[6]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
        end
    end

    task automatic set_idle();
        rs_s2 = 5'd0; rt_s2 = 5'd0; waddr_s3 = 5'd0;
        uses_rs_s2 = 1'b0; uses_rt_s2 = 1'b0; sel_mem_s3 = 1'b0; rw_s3 = 1'b0;
        branch_taken_s3 = 1'b0; mem_req_s4 = 1'b0; mem_ack = 1'b0; halt_s4 = 1'b0;
    endtask

    task automatic set_random();
        rs_s2 = 5'($urandom_range(0, 3)); rt_s2 = 5'($urandom_range(0, 3));
        waddr_s3 = 5'($urandom_range(0, 3));
        uses_rs_s2 = 1'($urandom); uses_rt_s2 = 1'($urandom);
        sel_mem_s3 = 1'($urandom); rw_s3 = 1'($urandom);
        branch_taken_s3 = ($urandom_range(0, 3) == 0);
        mem_req_s4 = 1'($urandom); mem_ack = 1'($urandom);
        halt_s4 = ($urandom_range(0, 39) == 0);
    endtask

    task automatic set_lu(input logic [4:0] r);
        set_idle();
        sel_mem_s3 = 1'b1; rw_s3 = 1'b1; waddr_s3 = r; rs_s2 = r; uses_rs_s2 = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tick(); rst_ = 1'b0; set_idle();
        tick(); rst_ = 1'b1;
    endtask

    initial begin
        set_idle();
        #2;
        check("reset_outputs", {24'd0, got}, 32'd0);
        check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        tick(); rst_ = 1'b1;

        // Load-use on r5, then the load moves on.
        tick(); set_lu(5'd5); #2;
        check("load_use_stall", {24'd0, got}, {24'd0, O_LU});
        tick(); set_idle(); #2;
        check("load_use_one_cycle", {24'd0, got}, 32'd0);
        check("load_use_cnt", {16'd0, stall_cnt}, 32'd1);
        tick(); set_lu(5'd0); #2;
        check("x0_no_stall", {24'd0, got}, 32'd0);
        tick(); set_lu(5'd7); branch_taken_s3 = 1'b1; #2;
        check("branch_over_load_use", {24'd0, got}, {24'd0, O_BR});

        // Memory access acknowledged on the fourth cycle.
        for (int i = 0; i < 4; i++) begin
            tick(); set_idle(); mem_req_s4 = 1'b1; mem_ack = (i == 3); #2;
            check("mem_wait_cycle", {24'd0, got}, (i < 3) ? {24'd0, O_MEM} : 32'd0);
        end
        tick(); set_idle(); #2;
        check("mem_back_to_run", {24'd0, got}, 32'd0);
        check("mem_stall_cnt", {16'd0, stall_cnt}, 32'd4);

        // Reset in the middle of a memory wait.
        tick(); mem_req_s4 = 1'b1; mem_ack = 1'b0;
        tick(); #2;
        check("in_mem_wait", {24'd0, got}, {24'd0, O_MEM});
        rst_ = 1'b0; set_idle(); #1;
        check("rst_mid_wait_outputs", {24'd0, got}, 32'd0);
        check("rst_mid_wait_cnt", {16'd0, stall_cnt}, 32'd0);
        tick(); rst_ = 1'b1;
        tick(); #2;
        check("no_pending_after_rst", {24'd0, got}, 32'd0);

        // Halt pulse: two drain cycles then sticky halted regardless of inputs.
        tick(); halt_s4 = 1'b1; #2;
        check("halt_accept", {24'd0, got}, {24'd0, O_DRAIN});
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k <= 2) set_idle(); else set_random();
            #2;
            check("halt_sequence", {24'd0, got}, (k <= 2) ? {24'd0, O_DRAIN} : {24'd0, O_HALT});
            if (k == 12) check("halt_stall_cnt", {16'd0, stall_cnt}, 32'd12);
        end
        check("stall_cnt_saturated", {28'd0, s_stall_cnt}, 32'd15);

        // Halt with a memory wait during drain delays HALTED by two cycles.
        pulse_reset();
        tick(); set_idle(); halt_s4 = 1'b1; #2;
        check("halt2_accept", {24'd0, got}, {24'd0, O_DRAIN});
        for (int k = 1; k <= 5; k++) begin
            tick(); set_idle();
            if (k <= 3) mem_req_s4 = 1'b1;
            mem_ack = (k == 3);
            #2;
            check("drain_freeze", {24'd0, got},
                  (k <= 2) ? {24'd0, O_MEM} : (k <= 4) ? {24'd0, O_DRAIN} : {24'd0, O_HALT});
        end

        // Random traffic with occasional resets.
        pulse_reset();
        for (int n = 0; n < 4000; n++) begin
            tick();
            set_random();
            rst_ = ($urandom_range(0, 63) != 0);
        end
        tick(); rst_ = 1'b1; set_idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
